utmi_rx_decoder: RTL



---
 rtl/utmi_rx_pkg.sv | 24 ++
 rtl/utmi_rx_decoder_if.sv | 22 ++
 rtl/utmi_rx_unstuff.sv | 59 +++++
 rtl/utmi_rx_decoder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/utmi_rx_pkg.sv
// Shared constants for the full-speed UTMI receive path: FSM state codes,
// line-state codes and default stuffing/SYNC thresholds.
package utmi_rx_pkg;

  localparam int STUFF_LIMIT_DEF    = 6;
  localparam int SYNC_MIN_ZEROS_DEF = 5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_EOP  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Line-state codes are {dm, dp}
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  function automatic logic is_jk(input logic [1:0] ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/utmi_rx_decoder_if.sv
// Bit-level line input and UTMI-style receive outputs of the decoder.
// The decoder uses the slave view; the line driver / protocol side uses master.
interface utmi_rx_decoder_if;
  logic       sample;
  logic       dp;
  logic       dm;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic [1:0] line_state;

  modport master (
    output sample, dp, dm,
    input  rx_data, rx_valid, rx_active, rx_error, line_state
  );

  modport slave (
    input  sample, dp, dm,
    output rx_data, rx_valid, rx_active, rx_error, line_state
  );
endinterface

// File: rtl/utmi_rx_unstuff.sv
// Bit-unstuffing stage: counts consecutive decoded ones and decides whether the
// next bit is data, a stuffed zero to drop, or a stuffing violation.
module utmi_rx_unstuff
  import utmi_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic bit_in,
  input  logic bit_in_valid,
  input  logic load_sync,
  output logic bit_out,
  output logic bit_out_valid,
  output logic stuff_err
);

  localparam int CW = $clog2(STUFF_LIMIT + 1);

  logic [CW-1:0] ones_cnt_r;
  logic          at_limit_s;

  assign at_limit_s = (ones_cnt_r == CW'(STUFF_LIMIT));
  assign bit_out    = bit_in;

  // Drop/error decision for the current decoded bit
  always_comb begin
    bit_out_valid = 1'b0;
    stuff_err     = 1'b0;
    if (bit_in_valid) begin
      if (at_limit_s) begin
        stuff_err = bit_in;
      end else begin
        bit_out_valid = 1'b1;
      end
    end else begin
      bit_out_valid = 1'b0;
      stuff_err     = 1'b0;
    end
  end

  // Run-length counter of ones; the SYNC terminating one seeds it at 1
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ones_cnt_r <= '0;
    end else if (load_sync) begin
      ones_cnt_r <= CW'(1);
    end else if (bit_in_valid) begin
      if (at_limit_s) begin
        ones_cnt_r <= '0;
      end else if (bit_in) begin
        ones_cnt_r <= ones_cnt_r + CW'(1);
      end else begin
        ones_cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/utmi_rx_decoder.sv
// Full-speed UTMI receive decoder: NRZI decode, SYNC/EOP detection, bit
// unstuffing and LSB-first deserialisation, all advanced on the sample strobe.
module utmi_rx_decoder
  import utmi_rx_pkg::*;
#(
  parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF,
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF
) (
  input logic              CLK,
  input logic              RST,
  utmi_rx_decoder_if.slave bus
);

  logic [2:0] state_r;
  logic       prev_level_r;   // 1 = J, 0 = K
  logic [2:0] zero_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shreg_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       rx_active_r;
  logic       rx_error_r;
  logic [1:0] line_state_r;

  logic [1:0] ls_s;
  logic       jk_s;
  logic       lvl_j_s;
  logic       dec_bit_s;
  logic       sync_ok_s;
  logic       us_valid_s;
  logic       load_sync_s;
  logic       bit_out_s;
  logic       bit_out_valid_s;
  logic       stuff_err_s;
  logic [7:0] byte_next_s;

  assign ls_s        = {bus.dm, bus.dp};
  assign jk_s        = is_jk(ls_s);
  assign lvl_j_s     = (ls_s == LS_J);
  assign dec_bit_s   = (lvl_j_s == prev_level_r);
  assign sync_ok_s   = dec_bit_s && (zero_cnt_r >= 3'(SYNC_MIN_ZEROS));
  assign us_valid_s  = bus.sample && jk_s && (state_r == ST_DATA);
  assign load_sync_s = bus.sample && jk_s && (state_r == ST_SYNC) && sync_ok_s;
  assign byte_next_s = {bit_out_s, shreg_r[7:1]};

  utmi_rx_unstuff #(
    .STUFF_LIMIT (STUFF_LIMIT)
  ) u_unstuff (
    .CLK           (CLK),
    .RST           (RST),
    .bit_in        (dec_bit_s),
    .bit_in_valid  (us_valid_s),
    .load_sync     (load_sync_s),
    .bit_out       (bit_out_s),
    .bit_out_valid (bit_out_valid_s),
    .stuff_err     (stuff_err_s)
  );

  // Receive FSM, shift register and registered UTMI outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r      <= ST_IDLE;
      prev_level_r <= 1'b1;
      zero_cnt_r   <= 3'd0;
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'h00;
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      rx_active_r  <= 1'b0;
      rx_error_r   <= 1'b0;
      line_state_r <= LS_J;
    end else begin
      rx_valid_r <= 1'b0;
      rx_error_r <= 1'b0;
      if (bus.sample) begin
        line_state_r <= ls_s;
        if (jk_s) begin
          prev_level_r <= lvl_j_s;
        end
        case (state_r)
          ST_IDLE: begin
            if (ls_s == LS_K) begin
              state_r    <= ST_SYNC;
              zero_cnt_r <= 3'd1;
            end
          end
          ST_SYNC: begin
            if (!jk_s) begin
              state_r <= ST_IDLE;
            end else if (!dec_bit_s) begin
              if (zero_cnt_r != 3'd7) begin
                zero_cnt_r <= zero_cnt_r + 3'd1;
              end
            end else if (sync_ok_s) begin
              state_r     <= ST_DATA;
              rx_active_r <= 1'b1;
              bit_cnt_r   <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DATA: begin
            // Line level is checked before the unstuffer, which only sees J/K
            if (ls_s == LS_SE0) begin
              state_r   <= ST_EOP;
              bit_cnt_r <= 3'd0;
            end else if ((ls_s == LS_SE1) || stuff_err_s) begin
              state_r     <= ST_ERR;
              rx_active_r <= 1'b0;
              rx_error_r  <= 1'b1;
            end else if (bit_out_valid_s) begin
              shreg_r   <= byte_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rx_data_r  <= byte_next_s;
                rx_valid_r <= 1'b1;
              end
            end
          end
          ST_EOP: begin
            if (ls_s == LS_J) begin
              state_r     <= ST_IDLE;
              rx_active_r <= 1'b0;
            end else if (ls_s != LS_SE0) begin
              state_r     <= ST_ERR;
              rx_active_r <= 1'b0;
              rx_error_r  <= 1'b1;
            end
          end
          ST_ERR: begin
            if (ls_s == LS_J) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            rx_active_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.rx_active  = rx_active_r;
  assign bus.rx_error   = rx_error_r;
  assign bus.line_state = line_state_r;

endmodule
